// File: rtl/case_statement.sv
// 4:1 bit selector driven by a full case on sel, with a validity flag.
// Optional macro CASE_STATEMENT_REG_EN registers the selected bit (one-cycle latency).
module case_statement (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       out,
  output logic       out_valid
);

  localparam int unsigned A_W   = 4;
  localparam int unsigned SEL_W = 2;

  logic [A_W-1:0]   w_a;
  logic [SEL_W-1:0] w_sel;
  logic             w_sel_bit;

  assign w_a   = a;
  assign w_sel = sel;

  // Bit selection; default keeps the decode fully specified.
  always_comb begin
    w_sel_bit = 1'b0;
    case (w_sel)
      2'b00:   w_sel_bit = w_a[0];
      2'b01:   w_sel_bit = w_a[1];
      2'b10:   w_sel_bit = w_a[2];
      2'b11:   w_sel_bit = w_a[3];
      default: w_sel_bit = 1'b0;
    endcase
  end

`ifdef CASE_STATEMENT_REG_EN
  logic r_out;
  logic r_valid;

  // Reset wins over the sample taken in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_sel_bit;
      r_valid <= 1'b1;
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
`else
  logic r_rst_q;

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  assign out       = w_sel_bit;
  assign out_valid = ~r_rst_q;
`endif

endmodule

// File: tb/tb_case_statement.sv
// Scoreboard bench for case_statement; follows CASE_STATEMENT_REG_EN for expected latency.
module tb_case_statement;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = 4'b0000;
  logic [1:0] sel = 2'b00;
  logic       out;
  logic       out_valid;

  case_statement dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   chk_cyc;
    logic exp_out;
    logic exp_valid;
    logic [3:0] a_v;
    logic [1:0] sel_v;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  logic last_sampled_rst = 1'b1;
  bit   drv_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endfunction

  // Reference: the selected bit is simply bit number sel of a.
  function automatic logic model_bit(input logic [3:0] av, input logic [1:0] sv);
    int unsigned idx;
    idx = int'(sv);
    return logic'((int'(av) >> idx) & 1);
  endfunction

  task automatic drive(input logic r, input logic [3:0] av, input logic [1:0] sv);
    exp_t e;
    @(posedge clk);
    last_sampled_rst = rst;
    #1;
    rst = r;
    a   = av;
    sel = sv;
    e.a_v   = av;
    e.sel_v = sv;
`ifdef CASE_STATEMENT_REG_EN
    e.chk_cyc   = cyc + 1;
    e.exp_out   = r ? 1'b0 : model_bit(av, sv);
    e.exp_valid = ~r;
`else
    e.chk_cyc   = cyc;
    e.exp_out   = model_bit(av, sv);
    e.exp_valid = ~last_sampled_rst;
`endif
    q.push_back(e);
  endtask

  // Monitor: pops the expectation due this cycle and compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].chk_cyc < cyc) begin
        e = q.pop_front();
        check("stale_expectation", 1'b1, 1'b0);
      end
      if (q.size() > 0 && q[0].chk_cyc == cyc) begin
        e = q.pop_front();
        check($sformatf("out a=%b sel=%b", e.a_v, e.sel_v), out, e.exp_out);
        check("out_valid", out_valid, e.exp_valid);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       r;
    logic [3:0] av;
    logic [1:0] sv;

    // Two reset cycles with data present.
    drive(1'b1, 4'b1100, 2'b00);
    drive(1'b1, 4'b1100, 2'b00);

    // sel stepped every two cycles on a=1100.
    for (int s = 0; s < 4; s++) begin
      drive(1'b0, 4'b1100, 2'(s));
      drive(1'b0, 4'b1100, 2'(s));
    end

    // sel=11 held, a toggled; only a[3] matters.
    drive(1'b0, 4'b1000, 2'b11);
    drive(1'b0, 4'b1000, 2'b11);
    drive(1'b0, 4'b0111, 2'b11);
    drive(1'b0, 4'b0111, 2'b11);
    drive(1'b0, 4'b1001, 2'b11);
    drive(1'b0, 4'b1110, 2'b11);

    // Back-to-back sel changes on a=1010.
    for (int s = 0; s < 4; s++) drive(1'b0, 4'b1010, 2'(s));

    // Reset pulse while out=1, then resume.
    drive(1'b0, 4'b1000, 2'b11);
    drive(1'b1, 4'b1000, 2'b11);
    drive(1'b0, 4'b1000, 2'b11);
    drive(1'b0, 4'b1000, 2'b11);

`ifndef CASE_STATEMENT_REG_EN
    // Combinational path: output follows inputs without a clock edge.
    drive(1'b0, 4'b0000, 2'b00);
    @(negedge clk);
    #2;
    a   = 4'b0100;
    sel = 2'b10;
    #1;
    check("comb_no_edge a=0100 sel=10", out, 1'b1);
    a   = 4'b1011;
    #1;
    check("comb_no_edge a=1011 sel=10", out, 1'b0);
`endif

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 19) == 0);
      av = 4'($urandom_range(0, 15));
      sv = 2'($urandom_range(0, 3));
      drive(r, av, sv);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", logic'(q.size() == 0), 1'b1);
    drv_done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/case_statement.md
CASE_STATEMENT -- requirements
Module: case_statement

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: a  input  4  data inputs, a[0]..a[3].
REQ-004 SHALL have port: sel  input  2  select code choosing one bit of a.
REQ-005 SHALL have port: out  output  1  selected data bit.
REQ-006 SHALL have port: out_valid  output  1  high when out reflects a sampled (a, sel) pair.
REQ-007 SHALL treat a, sel and all outputs as the design's one clock domain (clk); the module has one clock, and reset is synchronous and active-high.

Function
REQ-008 SHALL implement selection as a full case on sel:
- 2'b00 -> a[0]
- 2'b01 -> a[1]
- 2'b10 -> a[2]
- 2'b11 -> a[3]
REQ-009 SHALL include a default case item that selects 1'b0, so no latch is inferred and the logic is fully specified.
REQ-010 SHALL, with CASE_STATEMENT_REG_EN defined, register the selected bit into out on each rising clk edge, giving a latency of exactly one cycle from (a, sel) to out.
REQ-011 SHALL, with CASE_STATEMENT_REG_EN defined, set out_valid to 1 on the first rising edge with rst low and hold it at 1 until the next reset.
REQ-012 SHALL, with CASE_STATEMENT_REG_EN undefined, drive out combinationally from the current a and sel with zero latency.
REQ-013 SHALL, with CASE_STATEMENT_REG_EN undefined, tie out_valid to the inverse of a registered copy of rst: out_valid is 0 during reset and 1 from the first post-reset edge.
REQ-014 SHALL make a change of sel in any cycle, including back-to-back changes every cycle, take effect in out per REQ-010 or REQ-012 with no glitch-filtering or hold.
REQ-015 SHALL make a change of a with sel held constant propagate to out with the same latency as a sel change.
REQ-016 SHALL have no dependency on the non-selected bits of a.

Reset
REQ-017 SHALL, while rst is high at a rising clk edge, clear the out register (registered mode) and out_valid to 0.
REQ-018 SHALL give rst priority over data sampling in the same cycle; any (a, sel) presented in that cycle is discarded.
REQ-019 SHALL, on reset asserted mid-operation, force out (registered mode) and out_valid to 0 on the next edge.
REQ-020 SHALL, after rst deasserts, produce the first valid out from the (a, sel) sampled on the first edge with rst low.

Configuration
REQ-021 SHALL support the macro CASE_STATEMENT_REG_EN:
- defined: registered output, one-cycle latency, out resets to 0.
- undefined: combinational output; reset affects only out_valid.
REQ-022 SHALL keep identical port lists in both configurations.

Verification
REQ-023 SHALL cover: rst=1 for 2 cycles, a=4'b1100, sel=2'b00 -> out=0 (registered mode), out_valid=0.
REQ-024 SHALL cover: a=4'b1100 with sel stepped 00, 01, 10, 11 every 2 cycles -> out = 0, 0, 1, 1 respectively, one cycle after each change in registered mode.
REQ-025 SHALL cover: sel=2'b11 held, a toggled 4'b1000 -> 4'b0111 -> out goes 1 -> 0 with one-cycle latency; no response to a[2:0] changes.
REQ-026 SHALL cover: a=4'b1010 with sel changed every cycle 00, 01, 10, 11 -> out sequence 0, 1, 0, 1 in consecutive cycles.
REQ-027 SHALL cover: rst pulsed high for 1 cycle while out=1 -> out=0 and out_valid=0 on the next edge, then normal operation resumes on the following edge.
REQ-028 SHALL cover: macro undefined, a=4'b0100, sel=2'b10 -> out=1 in the same cycle with no clock edge required.
